// File: rtl/demux_16_14_buf_pkg.sv
// Shared datapath definitions for the 1-to-4 write distributor: default widths,
// lane index constants and the select decode helper.
package demux_16_14_buf_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int CNT_W_DEFAULT = 8;
    localparam int NUM_LANES     = 4;

    typedef logic [1:0] lane_sel_t;

    localparam lane_sel_t LANE_A = 2'd0;
    localparam lane_sel_t LANE_B = 2'd1;
    localparam lane_sel_t LANE_C = 2'd2;
    localparam lane_sel_t LANE_D = 2'd3;

    // One-hot lane mask for a destination select.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_sel_t sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/demux_16_14_buf_if.sv
// Source and per-lane consumer signals of the distributor, grouped as one bundle.
// Handshakes: a word moves on any rising edge where its valid and ready are both
// high; valid never depends on ready, and a producer holds its payload until then.
interface demux_16_14_buf_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;

    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_d;

    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [CNT_W-1:0] cnt_c;
    logic [CNT_W-1:0] cnt_d;

    // Distributor side.
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_c, out_d,
        output cnt_a, cnt_b, cnt_c, cnt_d
    );

    // Source plus consumers side.
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_c, out_d,
        input  cnt_a, cnt_b, cnt_c, cnt_d
    );

endinterface

// File: rtl/demux_16_14_buf_lane_buf.sv
// Single-entry output buffer for one consumer lane, with a wrapping count of
// completed output handshakes.
module demux_lane_buf #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] cnt
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drain;

    assign drain = full_q && ready;

    // A load in the same cycle as a drain replaces the departing word, so the
    // buffer stays full and the lane sustains one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (load) begin
            full_q <= 1'b1;
            data_q <= din;
        end else if (drain) begin
            full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (drain) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign valid = full_q;
    assign dout  = data_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/demux_16_14_buf.sv
// 16-bit 1-to-4 distributor: routes each accepted source word into the selected
// lane's single-entry buffer; each lane drains independently to its consumer.
module demux_16_14_buf
    import demux_16_14_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_16_14_buf_if.slave    bus
);

    logic [NUM_LANES-1:0] lane_valid;
    logic [NUM_LANES-1:0] lane_load;
    logic [WIDTH-1:0]     lane_dout [NUM_LANES];
    logic [CNT_W-1:0]     lane_cnt  [NUM_LANES];
    logic                 in_ready;

    // Only the selected lane gates the source, so a stalled lane never blocks
    // words bound elsewhere; in_valid is deliberately not part of this term.
    assign in_ready = !lane_valid[bus.in_sel] || bus.out_ready[bus.in_sel];

    always_comb begin
        lane_load = '0;
        if (bus.in_valid && in_ready) begin
            lane_load = lane_onehot(bus.in_sel);
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        demux_lane_buf #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (lane_load[k]),
            .din   (bus.in_data),
            .ready (bus.out_ready[k]),
            .valid (lane_valid[k]),
            .dout  (lane_dout[k]),
            .cnt   (lane_cnt[k])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = lane_valid;

    assign bus.out_a = lane_dout[LANE_A];
    assign bus.out_b = lane_dout[LANE_B];
    assign bus.out_c = lane_dout[LANE_C];
    assign bus.out_d = lane_dout[LANE_D];

    assign bus.cnt_a = lane_cnt[LANE_A];
    assign bus.cnt_b = lane_cnt[LANE_B];
    assign bus.cnt_c = lane_cnt[LANE_C];
    assign bus.cnt_d = lane_cnt[LANE_D];

endmodule

// File: tb/tb_demux_16_14_buf.sv
// Bench for the 1-to-4 distributor: directed scenarios plus constrained-random
// traffic, checked against a per-lane queue model of the buffers.
module tb_demux_16_14_buf;
    import demux_16_14_buf_pkg::*;

    localparam int W  = 16;
    localparam int CW = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_16_14_buf_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    demux_16_14_buf #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q [4][$];   // words buffered per lane, oldest first
    logic [W-1:0] exp_last [4];   // value each lane's output should show
    int unsigned  exp_cnt [4];    // completed handshakes per lane
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lane_out(input int k);
        case (k)
            0: return bus.out_a;
            1: return bus.out_b;
            2: return bus.out_c;
            default: return bus.out_d;
        endcase
    endfunction

    function automatic logic [CW-1:0] lane_cnt(input int k);
        case (k)
            0: return bus.cnt_a;
            1: return bus.cnt_b;
            2: return bus.cnt_c;
            default: return bus.cnt_d;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            exp_last[k] = '0;
            exp_cnt[k]  = 0;
        end
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_valid"}, 32'(bus.out_valid[k]), 32'(exp_q[k].size() != 0));
            check({tag, "_out"},   32'(lane_out(k)),      32'(exp_last[k]));
            check({tag, "_cnt"},   32'(lane_cnt(k)),      32'(exp_cnt[k] % (1 << CW)));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_out"}, 32'(lane_out(k)), 32'h0);
            check({tag, "_cnt"}, 32'(lane_cnt(k)), 32'h0);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already driven; returns at the next
    // falling edge after checking in_ready, deliveries and post-edge state.
    task automatic cycle(output bit acc);
        int  s;
        bit  rdy;
        #1;
        acc = 1'b0;
        s   = 0;
        if (bus.in_valid) begin
            s   = int'(bus.in_sel);
            rdy = (exp_q[s].size() == 0) || bus.out_ready[s];
            check("in_ready", 32'(bus.in_ready), 32'(rdy));
            acc = rdy;
        end
        for (int k = 0; k < 4; k++) begin
            if (exp_q[k].size() != 0 && bus.out_ready[k]) begin
                check("deliver", 32'(lane_out(k)), 32'(exp_q[k][0]));
                void'(exp_q[k].pop_front());
                exp_cnt[k]++;
            end
        end
        if (acc) begin
            exp_q[s].push_back(bus.in_data);
            exp_last[s] = bus.in_data;
        end
        @(posedge clk);
        #1;
        check_state("post_edge");
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        bit acc;
        cycle(acc);
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_sel   = 'x;
        bus.in_data  = 'x;
    endtask

    task automatic send(input logic [1:0] sel, input logic [W-1:0] data);
        bit acc;
        int tries;
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            cycle(acc);
            tries++;
        end
        if (!acc) check("send_timeout", 32'h0, 32'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        bit pending;

        drive_idle();
        bus.out_ready = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-cycle asynchronous reset with two lanes full.
        send(LANE_A, 16'h1234);
        send(LANE_C, 16'h5678);
        drive_idle();
        idle_cycle();
        check("pre_rst_valid", 32'(bus.out_valid), 32'h5);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic routing, all consumers ready.
        bus.out_ready = 4'b1111;
        send(LANE_A, 16'hA001);
        send(LANE_B, 16'hB002);
        send(LANE_C, 16'hC003);
        send(LANE_D, 16'hD004);
        drive_idle();
        repeat (2) idle_cycle();
        check("route_cnt_a", 32'(bus.cnt_a), 32'd1);
        check("route_cnt_b", 32'(bus.cnt_b), 32'd1);
        check("route_cnt_c", 32'(bus.cnt_c), 32'd1);
        check("route_cnt_d", 32'(bus.cnt_d), 32'd1);

        // Lane b stalled; other lanes keep flowing.
        do_reset();
        bus.out_ready = 4'b1101;
        send(LANE_B, 16'h1111);
        send(LANE_C, 16'h3333);
        bus.in_valid = 1'b1;
        bus.in_sel   = LANE_B;
        bus.in_data  = 16'h2222;
        repeat (3) cycle(acc);
        check("stall_ready", 32'(bus.in_ready), 32'h0);
        check("stall_out_b", 32'(bus.out_b), 32'h1111);
        check("stall_cnt_b", 32'(bus.cnt_b), 32'h0);
        check("stall_out_c", 32'(bus.out_c), 32'h3333);
        bus.out_ready = 4'b1111;
        send(LANE_B, 16'h2222);
        drive_idle();
        repeat (2) idle_cycle();
        check("stall_cnt_b_end", 32'(bus.cnt_b), 32'd2);

        // Simultaneous load and drain on lane a.
        do_reset();
        bus.out_ready = 4'b0000;
        send(LANE_A, 16'h00FF);
        drive_idle();
        idle_cycle();
        bus.out_ready = 4'b0001;
        send(LANE_A, 16'h0F0F);
        check("simul_out_a", 32'(bus.out_a), 32'h0F0F);
        check("simul_valid_a", 32'(bus.out_valid[0]), 32'h1);
        check("simul_cnt_a", 32'(bus.cnt_a), 32'h1);
        drive_idle();
        idle_cycle();

        // Counter wrap on lane d.
        do_reset();
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 255; i++) send(LANE_D, 16'(i));
        drive_idle();
        idle_cycle();
        check("wrap_cnt_255", 32'(bus.cnt_d), 32'd255);
        send(LANE_D, 16'hFFFF);
        drive_idle();
        idle_cycle();
        check("wrap_cnt_0", 32'(bus.cnt_d), 32'd0);

        // Back-to-back streaming on lane b.
        do_reset();
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 10; i++) send(LANE_B, 16'($urandom));
        drive_idle();
        idle_cycle();
        check("stream_cnt_b", 32'(bus.cnt_b), 32'd10);

        // Random traffic honouring the hold-until-accepted rule.
        do_reset();
        pending = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!pending) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_sel   = 2'($urandom_range(0, 3));
                    bus.in_data  = 16'($urandom);
                    pending      = 1'b1;
                end else begin
                    drive_idle();
                end
            end
            bus.out_ready = 4'($urandom_range(0, 15));
            cycle(acc);
            if (acc) pending = 1'b0;
        end
        drive_idle();
        bus.out_ready = 4'b1111;
        repeat (3) idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_16_14_buf.md
Name: demux_16_14_buf

Overview:
- 16-bit 1-to-4 distributor: the write-side counterpart of the 4:1 read-select mux in the datapath.
- Takes one source word plus a 2-bit destination select and delivers it to one of four consumer lanes (e.g. register-bank write ports).
- Each lane has its own single-entry output buffer and a valid/ready handshake, so one stalled consumer never blocks words bound for the other lanes.
- Keeps a per-lane delivered-word counter for debug and performance checks.

Parameters:
- WIDTH, 16, data word width.
- CNT_W, 8, width of each per-lane delivery counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  source word valid.
- in_ready  output  1  source word accepted this cycle when in_valid is also high.
- in_sel  input  2  destination lane: 0=a, 1=b, 2=c, 3=d.
- in_data  input  WIDTH  source word.
- out_valid  output  4  per-lane valid; bit k is lane k.
- out_ready  input  4  per-lane consumer ready.
- out_a, out_b, out_c, out_d  output  WIDTH each  lane buffer contents.
- cnt_a, cnt_b, cnt_c, cnt_d  output  CNT_W each  per-lane count of completed output handshakes.

Behaviour:
- Reset (async assert, sync-safe deassert) clears:
  - out_valid = 4'b0000,
  - out_a..out_d = 0,
  - cnt_a..cnt_d = 0.
- in_ready is combinational:
  - in_ready = !full[in_sel] || out_ready[in_sel], where full[k] == out_valid[k].
  - in_ready depends only on the selected lane.
  - in_ready does not depend on in_valid.
- Accept: in_valid && in_ready at a rising edge loads in_data into lane in_sel and sets out_valid[in_sel] = 1.
- Latency: a word accepted in cycle N is visible on its lane in cycle N+1.
- Drain: out_valid[k] && out_ready[k] at an edge completes lane k's transfer.
  - If lane k is not being loaded in that cycle: out_valid[k] clears.
  - cnt_k increments by 1, modulo 2^CNT_W (255 wraps to 0 for CNT_W=8).
- Simultaneous load and drain on the same lane:
  - The old word is delivered and the new word replaces it.
  - out_valid[k] stays 1 and cnt_k increments.
  - Full throughput is one word per cycle per lane.
- Stall: while out_valid[k] && !out_ready[k], out_k and out_valid[k] hold stable.
  - A new word for lane k sees in_ready = 0 and must wait.
  - Words for other lanes are accepted normally.
- Source rules:
  - in_data and in_sel are sampled only on an accepted edge.
  - The source holds in_valid, in_sel and in_data stable until accepted.
  - in_sel changing while in_valid is high and unaccepted is a protocol violation; the block takes no corrective action.
- Lane isolation: lanes not selected, or not draining, keep buffer, valid and counter unchanged.
- out_k after a drain retains the last delivered value; it is only meaningful while out_valid[k] = 1.
- No X propagation: with in_valid = 0, in_sel and in_data may be X without affecting state.
- Reset mid-operation: all buffered words are discarded and counters cleared immediately, with no handshake completion reported.

Decomposition:
- Shared package (datapath package) holds:
  - WIDTH default,
  - the lane index constants LANE_A = 2'd0, LANE_B = 2'd1, LANE_C = 2'd2, LANE_D = 2'd3.
- One sub-module is natural: demux_lane_buf, instantiated four times. It contains:
  - the single-entry buffer (data register plus full flag),
  - the load/drain logic,
  - the CNT_W counter.
  - Inputs: clk, rst_n, load, din, ready. Outputs: valid, dout, cnt.
- The top level holds only:
  - the 2-to-4 select decode (load_k = in_valid && in_ready && in_sel==k),
  - the in_ready mux.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with out_valid = 4'b0101 -> out_valid = 0, all out_* = 0, all cnt_* = 0 immediately, without waiting for a clock edge.
- Basic routing: all out_ready = 1; send 16'hA001 sel 0, 16'hB002 sel 1, 16'hC003 sel 2, 16'hD004 sel 3 on back-to-back cycles -> each word appears on its lane exactly one cycle after acceptance; cnt_a..cnt_d each = 1.
- Lane stall isolation: out_ready = 4'b1101 (lane b stalled); send 16'h1111 to b, then 16'h2222 to b, then 16'h3333 to c -> 16'h1111 is held on out_b; in_ready = 0 while 16'h2222 is offered; 16'h3333 then arrives on out_c the cycle after its acceptance; cnt_b stays 0 until out_ready[1] rises.
- Simultaneous load and drain: lane a full with 16'h00FF and out_ready[0] = 1; present 16'h0F0F sel 0 -> in_ready = 1; next cycle out_a = 16'h0F0F, out_valid[0] stays 1, cnt_a increments.
- Counter wrap: 256 drained words to lane d with CNT_W = 8 -> cnt_d reads 255 after 255 transfers and 0 after the 256th.
- Back-to-back streaming: one lane with out_ready held at 1, sel fixed, 10 consecutive valid words -> in_ready stays 1 throughout and all 10 words are delivered in order at one per cycle.
